// File: rtl/vga_pkg.sv
// vga_pkg: constants and helpers shared by the VGA pixel output stage.
//   - Visible area limits, RGB333 pixel width and the sprite transparency key.
//   - Flash sequencer state encoding.
//   - scanline_dim(): halves each 3-bit channel of an RGB333 pixel.
package vga_pkg;

  localparam int unsigned PIXEL_W = 9;

  localparam logic [9:0] H_VISIBLE_AREA = 10'd640;
  localparam logic [9:0] V_VISIBLE_AREA = 10'd480;

  localparam logic [PIXEL_W-1:0] TRANSPARENT_COLOR = 9'b111_000_111;

  typedef enum logic [1:0] {
    FLASH_IDLE   = 2'd0,
    FLASH_INVERT = 2'd1,
    FLASH_NORMAL = 2'd2
  } flash_state_t;

  // Shift every channel right by one; the top bit of each channel becomes 0.
  function automatic logic [PIXEL_W-1:0] scanline_dim(input logic [PIXEL_W-1:0] pixel);
    return {1'b0, pixel[8:7], 1'b0, pixel[5:4], 1'b0, pixel[2:1]};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: fixed-depth shift register used to keep sync and
// visible-area flags aligned with the pixel data coming back from memory.
//   i_Clk    pixel clock
//   i_Reset  asynchronous active-high reset, clears every stage to 0
//   i_Data   WIDTH-bit word entering the line
//   o_Data   the same word DEPTH clocks later
module sync_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift register stages, all cleared by reset.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= i_Data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign o_Data = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_pixel_output.sv
// vga_pixel_output: final video stage. Composites the sprite over the
// background with a transparency key, applies the flash inversion, blanks
// outside the visible area and registers the VGA pins. Also runs the
// frame-locked flash sequencer.
//
// Optional feature macro: SCANLINE_EN -- when defined, odd visible lines are
// darkened by halving each colour channel (no extra latency).
//
// Ports:
//   i_Clk, i_Reset            pixel clock, async active-high reset
//   i_H_Counter, i_V_Counter  counters from the sync generator
//   i_HSync, i_VSync          syncs aligned with the counters
//   i_Bg_Pixel                background RGB333, PIPE_DELAY clocks late
//   i_Sprite_Pixel/_Valid     sprite RGB333 and coverage, PIPE_DELAY late
//   i_Flash_Req               single-cycle flash start request
//   o_VGA_HSync/VSync         syncs, PIPE_DELAY+1 clocks after the counters
//   o_VGA_Red/Grn/Blu         colour channels, aligned with the syncs
//   o_Flash_Busy              request pending or sequence running
//   o_Frame_Start             pulse one clock after counters read (0,0)
module vga_pixel_output
  import vga_pkg::*;
#(
  parameter int unsigned PIPE_DELAY    = 2,
  parameter int unsigned FLASH_PERIOD  = 4,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic [9:0]   i_H_Counter,
  input  logic [9:0]   i_V_Counter,
  input  logic         i_HSync,
  input  logic         i_VSync,
  input  logic [8:0]   i_Bg_Pixel,
  input  logic [8:0]   i_Sprite_Pixel,
  input  logic         i_Sprite_Valid,
  input  logic         i_Flash_Req,
  output logic         o_VGA_HSync,
  output logic         o_VGA_VSync,
  output logic [2:0]   o_VGA_Red,
  output logic [2:0]   o_VGA_Grn,
  output logic [2:0]   o_VGA_Blu,
  output logic         o_Flash_Busy,
  output logic         o_Frame_Start
);

  localparam logic [7:0] FRAME_LAST  = 8'(FLASH_PERIOD - 1);
  localparam logic [7:0] TOGGLE_LAST = 8'(FLASH_TOGGLES - 1);

  // ---------------------------------------------------------------------------
  // Sync / visible flag delay, matched to the pixel memory latency
  // ---------------------------------------------------------------------------
  logic       visible_s;
  logic [3:0] flags_in_s;
  logic [3:0] flags_dly_s;
  logic       visible_dly_s;
  logic       hsync_dly_s;
  logic       vsync_dly_s;
  logic       v_lsb_dly_s;

  assign visible_s  = (i_H_Counter < H_VISIBLE_AREA) && (i_V_Counter < V_VISIBLE_AREA);
  assign flags_in_s = {visible_s, i_HSync, i_VSync, i_V_Counter[0]};

  sync_delay_line #(
    .WIDTH(4),
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay_line (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_Data (flags_in_s),
    .o_Data (flags_dly_s)
  );

  assign {visible_dly_s, hsync_dly_s, vsync_dly_s, v_lsb_dly_s} = flags_dly_s;

  // ---------------------------------------------------------------------------
  // Frame start pulse
  // ---------------------------------------------------------------------------
  logic frame_start_r;

  // Registered (0,0) detector; also the only event that moves the flash FSM.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= (i_H_Counter == 10'd0) && (i_V_Counter == 10'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Flash sequencer
  // ---------------------------------------------------------------------------
  flash_state_t state_r, state_next_s;
  logic         pending_r, pending_next_s;
  logic [7:0]   frame_cnt_r, frame_cnt_next_s;
  logic [7:0]   toggle_cnt_r, toggle_cnt_next_s;
  logic         busy_r, busy_next_s;

  // Flash FSM state and counters.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_r      <= FLASH_IDLE;
      pending_r    <= 1'b0;
      frame_cnt_r  <= 8'd0;
      toggle_cnt_r <= 8'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pending_r    <= pending_next_s;
      frame_cnt_r  <= frame_cnt_next_s;
      toggle_cnt_r <= toggle_cnt_next_s;
      busy_r       <= busy_next_s;
    end
  end

  // Flash FSM next state; transitions happen only on a frame start so a
  // colour change never lands mid-frame.
  always_comb begin
    state_next_s      = state_r;
    pending_next_s    = pending_r;
    frame_cnt_next_s  = frame_cnt_r;
    toggle_cnt_next_s = toggle_cnt_r;

    case (state_r)
      FLASH_IDLE: begin
        if (frame_start_r && pending_r) begin
          state_next_s      = FLASH_INVERT;
          pending_next_s    = 1'b0;
          frame_cnt_next_s  = 8'd0;
          toggle_cnt_next_s = 8'd0;
        end else if (i_Flash_Req) begin
          // A request on the same cycle as a frame start still waits a frame.
          pending_next_s = 1'b1;
        end else begin
          pending_next_s = pending_r;
        end
      end

      FLASH_INVERT, FLASH_NORMAL: begin
        // Requests while running are dropped, not queued.
        pending_next_s = 1'b0;
        if (frame_start_r) begin
          if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_next_s = 8'd0;
            if (toggle_cnt_r == TOGGLE_LAST) begin
              state_next_s      = FLASH_IDLE;
              toggle_cnt_next_s = 8'd0;
            end else begin
              toggle_cnt_next_s = toggle_cnt_r + 8'd1;
              state_next_s      = (state_r == FLASH_INVERT) ? FLASH_NORMAL : FLASH_INVERT;
            end
          end else begin
            frame_cnt_next_s = frame_cnt_r + 8'd1;
          end
        end else begin
          frame_cnt_next_s = frame_cnt_r;
        end
      end

      default: begin
        state_next_s      = FLASH_IDLE;
        pending_next_s    = 1'b0;
        frame_cnt_next_s  = 8'd0;
        toggle_cnt_next_s = 8'd0;
      end
    endcase

    busy_next_s = pending_next_s || (state_next_s != FLASH_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  logic [8:0] pixel_s;
  logic       sprite_opaque_s;

  assign sprite_opaque_s = i_Sprite_Valid && (i_Sprite_Pixel != TRANSPARENT_COLOR);

  // Composite, invert, optional scanline darkening, then blanking.
  always_comb begin
    if (sprite_opaque_s) begin
      pixel_s = i_Sprite_Pixel;
    end else begin
      pixel_s = i_Bg_Pixel;
    end

    if (state_r == FLASH_INVERT) begin
      pixel_s = ~pixel_s;
    end else begin
      pixel_s = pixel_s;
    end

`ifdef SCANLINE_EN
    if (visible_dly_s && v_lsb_dly_s) begin
      pixel_s = scanline_dim(pixel_s);
    end else begin
      pixel_s = pixel_s;
    end
`endif

    if (!visible_dly_s) begin
      pixel_s = 9'd0;
    end else begin
      pixel_s = pixel_s;
    end
  end

  logic [8:0] rgb_r;
  logic       hsync_r;
  logic       vsync_r;

  // Output registers: colour and sync leave on the same edge.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rgb_r   <= 9'd0;
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
    end else begin
      rgb_r   <= pixel_s;
      hsync_r <= hsync_dly_s;
      vsync_r <= vsync_dly_s;
    end
  end

  // v_lsb is only consumed by the scanline option.
  logic unused_s;
  assign unused_s = v_lsb_dly_s;

  assign o_VGA_Red     = rgb_r[8:6];
  assign o_VGA_Grn     = rgb_r[5:3];
  assign o_VGA_Blu     = rgb_r[2:0];
  assign o_VGA_HSync   = hsync_r;
  assign o_VGA_VSync   = vsync_r;
  assign o_Flash_Busy  = busy_r;
  assign o_Frame_Start = frame_start_r;

endmodule

// File: tb/tb_vga_pixel_output.sv
// tb_vga_pixel_output: directed self-checking bench for vga_pixel_output.
module tb_vga_pixel_output;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [9:0] i_H_Counter;
  logic [9:0] i_V_Counter;
  logic       i_HSync;
  logic       i_VSync;
  logic [8:0] i_Bg_Pixel;
  logic [8:0] i_Sprite_Pixel;
  logic       i_Sprite_Valid;
  logic       i_Flash_Req;
  logic       o_VGA_HSync;
  logic       o_VGA_VSync;
  logic [2:0] o_VGA_Red;
  logic [2:0] o_VGA_Grn;
  logic [2:0] o_VGA_Blu;
  logic       o_Flash_Busy;
  logic       o_Frame_Start;

  int tests  = 0;
  int failed = 0;

  vga_pixel_output dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_H_Counter   (i_H_Counter),
    .i_V_Counter   (i_V_Counter),
    .i_HSync       (i_HSync),
    .i_VSync       (i_VSync),
    .i_Bg_Pixel    (i_Bg_Pixel),
    .i_Sprite_Pixel(i_Sprite_Pixel),
    .i_Sprite_Valid(i_Sprite_Valid),
    .i_Flash_Req   (i_Flash_Req),
    .o_VGA_HSync   (o_VGA_HSync),
    .o_VGA_VSync   (o_VGA_VSync),
    .o_VGA_Red     (o_VGA_Red),
    .o_VGA_Grn     (o_VGA_Grn),
    .o_VGA_Blu     (o_VGA_Blu),
    .o_Flash_Busy  (o_Flash_Busy),
    .o_Frame_Start (o_Frame_Start)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One short synthetic frame: a (0,0) cycle, then pixels at (10,10).
  task automatic frame(input logic req_mid);
    i_H_Counter = 10'd0;
    i_V_Counter = 10'd0;
    step();
    i_H_Counter = 10'd10;
    i_V_Counter = 10'd10;
    i_Flash_Req = req_mid;
    step();
    i_Flash_Req = 1'b0;
    repeat (4) step();
  endtask

  logic [8:0] rgb;
  assign rgb = {o_VGA_Red, o_VGA_Grn, o_VGA_Blu};

  logic [8:0] exp_rgb;
  logic [8:0] exp_odd;

  initial begin
    i_Reset        = 1'b1;
    i_H_Counter    = 10'd0;
    i_V_Counter    = 10'd0;
    i_HSync        = 1'b0;
    i_VSync        = 1'b0;
    i_Bg_Pixel     = 9'h000;
    i_Sprite_Pixel = 9'h000;
    i_Sprite_Valid = 1'b0;
    i_Flash_Req    = 1'b0;
    repeat (3) step();

    chk("reset_rgb", rgb, 9'h000);
    chk("reset_sync", {7'd0, o_VGA_HSync, o_VGA_VSync}, 9'h000);
    chk("reset_busy_fs", {7'd0, o_Flash_Busy, o_Frame_Start}, 9'h000);

    // Latency: counters (0,0), red background, syncs high.
    i_Reset    = 1'b0;
    i_Bg_Pixel = 9'h1C0;
    i_HSync    = 1'b1;
    i_VSync    = 1'b1;
    step();
    chk("frame_start_pulse", {8'd0, o_Frame_Start}, 9'h001);
    chk("lat1_rgb", rgb, 9'h000);
    step();
    chk("lat2_rgb", rgb, 9'h000);
    chk("lat2_sync", {7'd0, o_VGA_HSync, o_VGA_VSync}, 9'h000);
    step();
    chk("lat3_red", rgb, 9'h1C0);
    chk("lat3_sync", {7'd0, o_VGA_HSync, o_VGA_VSync}, 9'h003);

    i_H_Counter = 10'd10;
    i_V_Counter = 10'd10;
    i_HSync     = 1'b0;
    i_VSync     = 1'b0;
    step();
    chk("frame_start_low", {8'd0, o_Frame_Start}, 9'h000);
    repeat (2) step();
    chk("sync_fall", {7'd0, o_VGA_HSync, o_VGA_VSync}, 9'h000);

    // Sprite compositing.
    i_Sprite_Pixel = 9'h038;
    i_Sprite_Valid = 1'b1;
    repeat (3) step();
    chk("sprite_green", rgb, 9'h038);
    i_Sprite_Pixel = 9'h1C7;
    repeat (3) step();
    chk("sprite_transparent", rgb, 9'h1C0);
    i_Sprite_Pixel = 9'h038;
    i_Sprite_Valid = 1'b0;
    repeat (3) step();
    chk("sprite_invalid", rgb, 9'h1C0);

    // Visible-area boundaries.
    i_Bg_Pixel  = 9'h1FF;
    i_H_Counter = 10'd640;
    repeat (3) step();
    chk("blank_h640", rgb, 9'h000);
    i_H_Counter = 10'd10;
    i_V_Counter = 10'd480;
    repeat (3) step();
    chk("blank_v480", rgb, 9'h000);
    i_H_Counter = 10'd639;
    i_V_Counter = 10'd478;
    repeat (3) step();
    chk("edge_visible", rgb, 9'h1FF);

    // Flash sequence on a black background.
    i_Bg_Pixel  = 9'h000;
    i_H_Counter = 10'd10;
    i_V_Counter = 10'd10;
    repeat (3) step();
    chk("pre_flash_busy", {8'd0, o_Flash_Busy}, 9'h000);
    i_Flash_Req = 1'b1;
    step();
    i_Flash_Req = 1'b0;
    chk("flash_busy_now", {8'd0, o_Flash_Busy}, 9'h001);
    repeat (3) step();
    chk("flash_pending_rgb", rgb, 9'h000);

    for (int k = 0; k < 25; k++) begin
      frame(k == 5);
      exp_rgb = ((k < 24) && (((k / 4) % 2) == 0)) ? 9'h1FF : 9'h000;
      chk($sformatf("flash_rgb_f%0d", k), rgb, exp_rgb);
      chk($sformatf("flash_busy_f%0d", k), {8'd0, o_Flash_Busy}, (k < 24) ? 9'h001 : 9'h000);
    end

    // Reset in the middle of an inverted frame.
    i_Flash_Req = 1'b1;
    step();
    i_Flash_Req = 1'b0;
    frame(1'b0);
    frame(1'b0);
    chk("mid_invert_rgb", rgb, 9'h1FF);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("async_reset_rgb", rgb, 9'h000);
    chk("async_reset_busy", {8'd0, o_Flash_Busy}, 9'h000);
    step();
    i_Reset    = 1'b0;
    i_Bg_Pixel = 9'h1C0;
    repeat (3) step();
    chk("post_reset_rgb", rgb, 9'h1C0);
    frame(1'b0);
    chk("post_reset_idle_rgb", rgb, 9'h1C0);
    chk("post_reset_idle_busy", {8'd0, o_Flash_Busy}, 9'h000);

    // Odd / even line appearance.
    i_Bg_Pixel  = 9'h1FF;
    i_V_Counter = 10'd11;
    repeat (3) step();
`ifdef SCANLINE_EN
    exp_odd = 9'h0DB;
`else
    exp_odd = 9'h1FF;
`endif
    chk("odd_line", rgb, exp_odd);
    i_V_Counter = 10'd12;
    repeat (3) step();
    chk("even_line", rgb, 9'h1FF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_pixel_output.md
# vga_pixel_output

Final stage of the video path: consumes the 9-bit RGB333 background pixel from the background tile renderer plus a sprite overlay pixel, composites them with a transparency key, blanks outside the visible area, and drives the VGA pins. Sync and visible-area flags are delayed to match the upstream memory-read latency so colour and sync stay aligned. It also runs a frame-locked screen-flash sequencer (colour inversion) used for game events.

## Interface
- PIPE_DELAY, 2, clocks between i_H_Counter/i_V_Counter and valid i_Bg_Pixel/i_Sprite_Pixel
- H_VISIBLE_AREA, 640, visible pixels per line
- V_VISIBLE_AREA, 480, visible lines per frame
- TRANSPARENT_COLOR, 9'b111_000_111, sprite key colour (not drawn)
- FLASH_PERIOD, 4, frames per flash half-cycle (≥1)
- FLASH_TOGGLES, 6, half-cycles per flash sequence (≥1)

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  asynchronous, active-high reset
- i_H_Counter  in  10  horizontal counter from sync generator
- i_V_Counter  in  10  vertical counter from sync generator
- i_HSync  in  1  horizontal sync, aligned with counters
- i_VSync  in  1  vertical sync, aligned with counters
- i_Bg_Pixel  in  9  background RGB333, PIPE_DELAY clocks late
- i_Sprite_Pixel  in  9  sprite RGB333, PIPE_DELAY clocks late
- i_Sprite_Valid  in  1  sprite covers this pixel, PIPE_DELAY clocks late
- i_Flash_Req  in  1  single-cycle request to start a flash sequence
- o_VGA_HSync  out  1  delayed hsync
- o_VGA_VSync  out  1  delayed vsync
- o_VGA_Red  out  3  red channel
- o_VGA_Grn  out  3  green channel
- o_VGA_Blu  out  3  blue channel
- o_Flash_Busy  out  1  high while flash sequence active
- o_Frame_Start  out  1  one-cycle pulse when input counters are (0,0)

## Operation
- Visible flag = (i_H_Counter < H_VISIBLE_AREA) && (i_V_Counter < V_VISIBLE_AREA), computed at input, delayed PIPE_DELAY clocks with i_HSync, i_VSync, i_V_Counter[0].
- Composite: sprite pixel if i_Sprite_Valid && i_Sprite_Pixel != TRANSPARENT_COLOR, else i_Bg_Pixel.
- Invert stage: when flash state is INVERT, pixel = ~pixel (all 9 bits).
- Blank: delayed visible flag low → pixel forced to 0.
- RGB split: Red = [8:6], Grn = [5:3], Blu = [2:0].
- Flash FSM states IDLE, INVERT, NORMAL:
  - IDLE: i_Flash_Req latched into pending flag; on next o_Frame_Start with pending set → INVERT, frame count = 0, toggle count = 0, pending cleared.
  - INVERT/NORMAL: each o_Frame_Start increments frame count; when it reaches FLASH_PERIOD−1 and another frame start occurs, toggle count increments, frame count clears, state alternates; after FLASH_TOGGLES half-cycles → IDLE.
  - i_Flash_Req while busy is ignored (not queued).
  - State changes only at frame start; no mid-frame tearing.
- o_Flash_Busy high when pending set or state ≠ IDLE.

## Timing
- Colour and sync outputs registered; total latency PIPE_DELAY+1 clocks from counters to pins; colour and sync emerge on the same edge.
- o_Frame_Start: registered, asserted one clock after input counters are (0,0).
- Flash state change takes effect on pixels of the frame starting at that frame-start pulse.
- Reset (any time, including mid-flash): all outputs 0, o_VGA_HSync/o_VGA_VSync 0, delay lines cleared, FSM IDLE, pending cleared, counters 0. Output valid again PIPE_DELAY+1 clocks after reset release.
- i_Flash_Req coincident with frame start in IDLE: pending set, sequence starts at the following frame start.

## Configuration
- SCANLINE_EN defined: on visible lines whose delayed V_Counter[0] = 1, each 3-bit channel shifted right by 1 (after inversion, before blanking); adds no latency.
- Undefined: no darkening; output identical for odd and even lines.

## Structure
- Shared include (vga_pkg): H_VISIBLE_AREA, V_VISIBLE_AREA, pixel width 9, TRANSPARENT_COLOR, flash state encodings.
- One sub-module: sync_delay_line (parameterized width/depth shift register, async reset to 0) carrying {visible, hsync, vsync, v_lsb}.

## Test plan
- Reset, counters (0,0), bg 9'h1C0, no sprite → after PIPE_DELAY+1 clocks Red=7, Grn=0, Blu=0; hsync/vsync edges appear same delay.
- Sprite pixel 9'h038 with valid → Grn=7 output; sprite pixel = TRANSPARENT_COLOR with valid → background shown.
- H_Counter = 640, bg 9'h1FF → outputs 0 (blanking).
- Flash_Req mid-frame → o_Flash_Busy high immediately; next frame start bg 9'h000 outputs 9'h1FF for 4 frames, normal 4 frames, total 6 half-cycles then IDLE, busy low.
- Second Flash_Req during flash → ignored; sequence length unchanged.
- Reset asserted mid-INVERT → outputs 0 at once; after release normal colours, FSM IDLE; with SCANLINE_EN, bg 9'h1FF on odd line → 3/3/3.
